display_scan: RTL and testbench

DISPLAY_SCAN -- requirements
Module: display_scan

---
 rtl/display_scan.sv | 112 +++++++++++
 tb/tb_display_scan.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/display_scan.sv
// display_scan: four-digit BCD entry buffer with a multiplexed 7-segment scan.
// Digits shift in from the right on each WR rising edge; LOAD replaces the whole
// buffer. One digit is lit at a time, each for SCAN_DIV clocks.
module display_scan #(
    parameter int SCAN_DIV = 64
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        WR,
    input  logic [3:0]  WR_DATA,
    input  logic        CLR,
    input  logic        LOAD,
    input  logic [15:0] LOAD_DATA,
    input  logic        BLANK_LZ,
    output logic [15:0] VALUE,
    output logic [2:0]  COUNT,
    output logic        OVF,
    output logic [3:0]  DIGIT_EN,
    output logic [6:0]  SEG
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

    logic [15:0]   digits;
    logic [2:0]    count;
    logic          ovf;
    logic          wr_q;
    logic          wr_edge;
    logic          digit_ok;
    logic [PW-1:0] presc;
    logic [1:0]    idx;
    logic [3:0]    cur;
    logic          z3, z2, z1;
    logic [3:0]    lead;

    // wr_q resets high so a key already down at reset release is not taken
    assign wr_edge  = WR & ~wr_q;
    assign digit_ok = (WR_DATA <= 4'd9);

    // Digit buffer, entry count and sticky overflow; CLR beats LOAD beats key entry
    always_ff @(posedge CLK) begin
        if (RESET) begin
            digits <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            wr_q   <= 1'b1;
        end else begin
            wr_q <= WR;
            if (CLR) begin
                digits <= '0;
                count  <= '0;
                ovf    <= 1'b0;
            end else if (LOAD) begin
                digits <= LOAD_DATA;
                count  <= 3'd4;
            end else if (wr_edge && digit_ok) begin
                if (count == 3'd4) begin
                    ovf <= 1'b1;
                end else begin
                    digits <= {digits[11:0], WR_DATA};
                    count  <= count + 3'd1;
                end
            end
        end
    end

    // Free-running prescaler; the scan index steps once per SCAN_DIV clocks
    always_ff @(posedge CLK) begin
        if (RESET) begin
            presc <= '0;
            idx   <= '0;
        end else if (presc == PRESC_MAX) begin
            presc <= '0;
            idx   <= idx + 2'd1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    assign VALUE    = digits;
    assign COUNT    = count;
    assign OVF      = ovf;
    assign DIGIT_EN = 4'b0001 << idx;
    assign cur      = digits[{idx, 2'b00} +: 4];

    // A digit is a leading zero when it and every digit to its left are zero;
    // the rightmost digit always shows
    assign z3   = (digits[15:12] == 4'd0);
    assign z2   = (digits[11:8]  == 4'd0);
    assign z1   = (digits[7:4]   == 4'd0);
    assign lead = {z3, z3 & z2, z3 & z2 & z1, 1'b0};

    // Segment decode of the selected digit; non-BCD codes and blanked zeros go dark
    always_comb begin
        SEG = 7'h00;
        if (!(BLANK_LZ && lead[idx])) begin
            case (cur)
                4'd0:    SEG = 7'h3F;
                4'd1:    SEG = 7'h06;
                4'd2:    SEG = 7'h5B;
                4'd3:    SEG = 7'h4F;
                4'd4:    SEG = 7'h66;
                4'd5:    SEG = 7'h6D;
                4'd6:    SEG = 7'h7D;
                4'd7:    SEG = 7'h07;
                4'd8:    SEG = 7'h7F;
                4'd9:    SEG = 7'h6F;
                default: SEG = 7'h00;
            endcase
        end
    end
endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan: directed stimulus against a digit-list model of the display,
// checked every cycle, plus hand-computed literal expectations.
module tb_display_scan;
    localparam int DIV = 4;

    logic        CLK = 1'b0;
    logic        RESET, WR, CLR, LOAD, BLANK_LZ;
    logic [3:0]  WR_DATA;
    logic [15:0] LOAD_DATA;
    logic [15:0] VALUE;
    logic [2:0]  COUNT;
    logic        OVF;
    logic [3:0]  DIGIT_EN;
    logic [6:0]  SEG;

    int n_pass = 0;
    int n_tot  = 0;

    display_scan #(.SCAN_DIV(DIV)) dut (
        .CLK(CLK), .RESET(RESET), .WR(WR), .WR_DATA(WR_DATA), .CLR(CLR),
        .LOAD(LOAD), .LOAD_DATA(LOAD_DATA), .BLANK_LZ(BLANK_LZ),
        .VALUE(VALUE), .COUNT(COUNT), .OVF(OVF), .DIGIT_EN(DIGIT_EN), .SEG(SEG)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- model: digits as a list, scan from elapsed cycles ----------------
    int m_d[4];           // m_d[0] is rightmost digit
    int m_count, m_ovf, m_prev_wr, m_cycles;
    logic [6:0] seg_tab[16];

    initial begin
        seg_tab[0] = 7'h3F; seg_tab[1] = 7'h06; seg_tab[2] = 7'h5B; seg_tab[3] = 7'h4F;
        seg_tab[4] = 7'h66; seg_tab[5] = 7'h6D; seg_tab[6] = 7'h7D; seg_tab[7] = 7'h07;
        seg_tab[8] = 7'h7F; seg_tab[9] = 7'h6F;
        for (int i = 10; i < 16; i++) seg_tab[i] = 7'h00;
        for (int i = 0; i < 4; i++) m_d[i] = 0;
        m_count = 0; m_ovf = 0; m_prev_wr = 1; m_cycles = 0;
    end

    function automatic logic [15:0] m_value();
        return 16'((m_d[3] << 12) | (m_d[2] << 8) | (m_d[1] << 4) | m_d[0]);
    endfunction

    // Inputs are held from negedge+1 through the following posedge, so at each
    // negedge they are exactly what the DUT sampled; advance model, then compare.
    always @(negedge CLK) begin
        int  sel, edge_seen;
        logic blank;
        if (RESET) begin
            for (int i = 0; i < 4; i++) m_d[i] = 0;
            m_count = 0; m_ovf = 0; m_prev_wr = 1; m_cycles = 0;
        end else begin
            edge_seen = (WR && !m_prev_wr) ? 1 : 0;
            m_prev_wr = WR ? 1 : 0;
            m_cycles++;
            if (CLR) begin
                for (int i = 0; i < 4; i++) m_d[i] = 0;
                m_count = 0; m_ovf = 0;
            end else if (LOAD) begin
                for (int i = 0; i < 4; i++) m_d[i] = int'(LOAD_DATA[i*4 +: 4]);
                m_count = 4;
            end else if (edge_seen != 0 && WR_DATA <= 9) begin
                if (m_count == 4) m_ovf = 1;
                else begin
                    for (int i = 3; i > 0; i--) m_d[i] = m_d[i-1];
                    m_d[0] = int'(WR_DATA);
                    m_count++;
                end
            end
        end
        sel   = (m_cycles / DIV) % 4;
        blank = 1'b0;
        if (BLANK_LZ && sel > 0) begin
            blank = 1'b1;
            for (int j = sel; j < 4; j++) if (m_d[j] != 0) blank = 1'b0;
        end
        chk("value",    VALUE,           m_value());
        chk("count",    16'(COUNT),      16'(m_count));
        chk("ovf",      16'(OVF),        16'(m_ovf));
        chk("digit_en", 16'(DIGIT_EN),   16'(4'b0001 << sel));
        chk("seg",      16'(SEG),        blank ? 16'h0 : 16'(seg_tab[m_d[sel]]));
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic pulse(input logic [3:0] d);
        WR = 1'b1; WR_DATA = d; tick();
        WR = 1'b0; tick();
    endtask

    task automatic seg_at(input int i, input logic [6:0] exp);
        int found = 0;
        #1;
        for (int k = 0; k < 40 && found == 0; k++) begin
            if (DIGIT_EN == (4'b0001 << i)) found = 1;
            else tick();
        end
        if (found == 0) chk($sformatf("digit%0d_timeout", i), 16'(DIGIT_EN), 16'(4'b0001 << i));
        else            chk($sformatf("lit_seg_d%0d", i), 16'(SEG), 16'(exp));
    endtask

    initial begin
        RESET = 1'b1; WR = 1'b0; WR_DATA = 4'd0; CLR = 1'b0; LOAD = 1'b0;
        LOAD_DATA = 16'h0; BLANK_LZ = 1'b0;
        tick(); tick();
        chk("lit_rst_digit_en", 16'(DIGIT_EN), 16'h1);
        chk("lit_rst_seg",      16'(SEG),      16'h3F);
        chk("lit_rst_count",    16'(COUNT),    16'h0);
        RESET = 1'b0; tick();

        // 1,2,3 entered, leading zero blanked
        pulse(4'd1); pulse(4'd2); pulse(4'd3);
        chk("lit_val_0123", VALUE, 16'h0123);
        chk("lit_cnt_3", 16'(COUNT), 16'h3);
        BLANK_LZ = 1'b1;
        seg_at(3, 7'h00); seg_at(2, 7'h06); seg_at(1, 7'h5B); seg_at(0, 7'h4F);
        BLANK_LZ = 1'b0;

        // overflow on fifth digit, then clear
        CLR = 1'b1; tick(); CLR = 1'b0;
        for (int d = 1; d <= 5; d++) pulse(4'(d));
        chk("lit_val_1234", VALUE, 16'h1234);
        chk("lit_ovf_set", 16'(OVF), 16'h1);
        CLR = 1'b1; tick(); CLR = 1'b0; tick();
        chk("lit_clr_val", VALUE, 16'h0);
        chk("lit_clr_ovf", 16'(OVF), 16'h0);

        // held key enters once; non-BCD ignored
        WR = 1'b1; WR_DATA = 4'd7;
        repeat (20) tick();
        WR = 1'b0; tick();
        chk("lit_hold_val", VALUE, 16'h0007);
        chk("lit_hold_cnt", 16'(COUNT), 16'h1);
        pulse(4'hC);
        chk("lit_nonbcd_val", VALUE, 16'h0007);

        // scan sequence from reset, with wrap
        RESET = 1'b1; tick(); RESET = 1'b0;
        for (int k = 0; k <= 16; k++) begin
            chk($sformatf("lit_scan_%0d", k), 16'(DIGIT_EN), 16'(4'b0001 << ((k / 4) % 4)));
            tick();
        end

        // LOAD wins over a same-cycle key edge
        WR = 1'b1; WR_DATA = 4'd5; LOAD = 1'b1; LOAD_DATA = 16'hA905; tick();
        LOAD = 1'b0; WR = 1'b0; tick();
        chk("lit_load_val", VALUE, 16'hA905);
        chk("lit_load_cnt", 16'(COUNT), 16'h4);
        BLANK_LZ = 1'b1;
        seg_at(3, 7'h00); seg_at(2, 7'h6F); seg_at(1, 7'h3F); seg_at(0, 7'h6D);
        BLANK_LZ = 1'b0;

        // key edge lost to CLR is not deferred
        WR = 1'b1; WR_DATA = 4'd3; CLR = 1'b1; tick();
        CLR = 1'b0; tick(); tick();
        WR = 1'b0; tick();
        chk("lit_clr_wins", 16'(COUNT), 16'h0);

        // key held through reset release is not entered
        RESET = 1'b1; WR = 1'b1; WR_DATA = 4'd4; tick(); tick();
        RESET = 1'b0; tick(); tick(); tick();
        chk("lit_rst_hold_cnt", 16'(COUNT), 16'h0);
        WR = 1'b0; tick(); WR = 1'b1; tick(); WR = 1'b0; tick();
        chk("lit_rst_rel_val", VALUE, 16'h0004);
        chk("lit_rst_rel_cnt", 16'(COUNT), 16'h1);

        tick();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
